// File: rtl/general1_pkg.sv
// Shared display helpers: width functions, nibble codes, the seven-segment
// encoder and the converter FSM state type.
package General1;

  localparam logic [3:0] EmptyCode = 4'hA;
  localparam logic [3:0] MinusCode = 4'hB;
  localparam logic [7:0] EmptySeg  = 8'hFF;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  // Returns at least 1 so it can always size a vector.
  function automatic int clog2(input int x);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << n) < x) n++;
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int clog10(input longint unsigned x);
    int n;
    longint unsigned p;
    n = 0;
    p = 1;
    for (int i = 0; i < 20; i++)
      if (p < x) begin
        p = p * 10;
        n++;
      end
    return n;
  endfunction

  // Common-anode pattern {dp,g,f,e,d,c,b,a}, active low, dp off.
  function automatic logic [7:0] BCD2ESC(input logic [3:0] n);
    case (n)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      MinusCode: return 8'hBF;
      default: return EmptySeg;
    endcase
  endfunction

endpackage

// File: rtl/SelectNPulse.sv
// Free-running divider: Pulse is high for one cycle out of every N.
module SelectNPulse #(
  parameter int N = 2
) (
  input  logic Clock,
  input  logic ResetN,
  output logic Pulse
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt_q;

  assign Pulse = (cnt_q == W'(N - 1));

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) cnt_q <= '0;
    else if (Pulse) cnt_q <= '0;
    else cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/bin2bcd_serial.sv
// Sequential double-dabble: one add-3/shift iteration per clock, Size iterations.
// Done marks the cycle of the final iteration; BCD is complete on the next cycle.
module bin2bcd_serial import General1::*; #(
  parameter int Size   = 8,
  parameter int Digits = 3
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Start,
  input  logic [Size-1:0]       Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*Digits-1:0]   BCD
);

  localparam int CW = clog2(Size + 1);

  logic [Size-1:0]     bin_q;
  logic [4*Digits-1:0] bcd_q, adj_d;
  logic [CW-1:0]       cnt_q;

  assign Busy = (cnt_q != '0);
  assign Done = (cnt_q == CW'(1));
  assign BCD  = bcd_q;

  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < Digits; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (Start && !Busy) begin
      bin_q <= Bin;
      bcd_q <= '0;
      cnt_q <= CW'(Size);
    end else if (Busy) begin
      {bcd_q, bin_q} <= {adj_d[4*Digits-2:0], bin_q, 1'b0};
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/segment_display_ctrl.sv
// Multiplexed seven-segment controller: serial BCD conversion, leading-zero
// blanking with floating minus, digit scan, PWM brightness and blink.
module segment_display_ctrl import General1::*; #(
  parameter int    Size           = 8,
  parameter string Signed         = "Yes",
  parameter int    ClockPeriod_ns = 20,
  parameter int    RefreshTime_ns = 200_000,
  parameter int    BlinkTime_ns   = 250_000_000,
  parameter int    BrightLevels   = 8,
  localparam int   ISize = clog10(64'd1 << Size) + ((Signed == "Yes") ? 1 : 0)
) (
  input  logic                            Clock,
  input  logic                            ResetN,
  input  logic                            Load,
  input  logic [Size-1:0]                 Data,
  input  logic                            BlankZeros,
  input  logic                            Blink,
  input  logic [clog2(BrightLevels)-1:0]  Brightness,
  output logic                            Busy,
  output logic [ISize-1:0]                Indicators,
  output logic [7:0]                      Segments
);

  localparam bit IsSigned    = (Signed == "Yes");
  localparam int Digits      = clog10(64'd1 << Size);
  localparam int DW          = clog2(ISize);
  localparam int BW          = clog2(BrightLevels);
  localparam int ScanCycles  = RefreshTime_ns / ClockPeriod_ns / ISize;
  localparam int BlinkCycles = BlinkTime_ns / ClockPeriod_ns;

  state_t                   state_q;
  logic                     busy_q, signPend_q, dispSign_q, dispSign_d;
  logic [Digits-1:0][3:0]   dispDig_q, dispDig_d;
  logic                     negIn, start, convBusy, convDone;
  logic [Size-1:0]          magIn;
  logic [4*Digits-1:0]      bcd;
  logic                     scanTick, blinkTick, phase_q, phase_d;
  logic [DW-1:0]            digit_q, digit_d;
  logic [BW-1:0]            pwm_q, pwm_d;
  logic [ISize-1:0]         ind_q, ind_d;
  logic [7:0]               seg_q;
  logic [3:0]               selNib;
  int                       msd, signPos;

  assign Busy       = busy_q;
  assign Indicators = ind_q;
  assign Segments   = seg_q;

  always_comb begin
    negIn = IsSigned && Data[Size-1];
    magIn = negIn ? -Data : Data;
    start = (state_q == IDLE) && Load && !convBusy;
  end

  bin2bcd_serial #(.Size(Size), .Digits(Digits)) conv (
    .Clock(Clock), .ResetN(ResetN), .Start(start), .Bin(magIn),
    .Busy(convBusy), .Done(convDone), .BCD(bcd)
  );

  SelectNPulse #(.N(ScanCycles))  scanDiv  (.Clock(Clock), .ResetN(ResetN), .Pulse(scanTick));
  SelectNPulse #(.N(BlinkCycles)) blinkDiv (.Clock(Clock), .ResetN(ResetN), .Pulse(blinkTick));

  always_comb begin
    dispDig_d  = dispDig_q;
    dispSign_d = dispSign_q;
    if (state_q == COMMIT) begin
      for (int i = 0; i < Digits; i++) dispDig_d[i] = bcd[4*i +: 4];
      dispSign_d = signPend_q;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      signPend_q <= 1'b0;
      dispDig_q  <= {Digits{EmptyCode}};
      dispSign_q <= 1'b0;
    end else begin
      dispDig_q  <= dispDig_d;
      dispSign_q <= dispSign_d;
      unique case (state_q)
        IDLE: if (start) begin
          state_q    <= CONVERT;
          busy_q     <= 1'b1;
          signPend_q <= negIn;
        end
        CONVERT: if (convDone) state_q <= COMMIT;
        COMMIT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state values so a commit shows on the
  // very cycle Busy drops, and reset leaves every pin inactive.
  always_comb begin
    digit_d = digit_q;
    if (scanTick) digit_d = (digit_q == '0) ? DW'(ISize - 1) : digit_q - DW'(1);
    pwm_d   = pwm_q + BW'(1);
    phase_d = phase_q ^ blinkTick;

    msd = 0;
    for (int i = 1; i < Digits; i++)
      if (dispDig_d[i] != 4'd0) msd = i;
    signPos = BlankZeros ? msd + 1 : ISize - 1;

    selNib = EmptyCode;
    if (int'(digit_d) < Digits)
      selNib = (BlankZeros && int'(digit_d) > msd) ? EmptyCode : dispDig_d[digit_d];
    if (IsSigned && int'(digit_d) == signPos)
      selNib = dispSign_d ? MinusCode : EmptyCode;

    ind_d = '1;
    if (!(Blink && phase_d) && pwm_d <= Brightness) ind_d[digit_d] = 1'b0;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      digit_q <= DW'(ISize - 1);
      pwm_q   <= '0;
      phase_q <= 1'b0;
      ind_q   <= '1;
      seg_q   <= EmptySeg;
    end else begin
      digit_q <= digit_d;
      pwm_q   <= pwm_d;
      phase_q <= phase_d;
      ind_q   <= ind_d;
      seg_q   <= BCD2ESC(selNib);
    end
  end

endmodule

// File: tb/tb_segment_display_ctrl.sv
// Scoreboard bench: an unsigned and a signed instance share stimulus; a monitor
// pops the expected digit patterns each time a conversion commits.
module tb_segment_display_ctrl;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       load = 1'b0;
  logic [7:0] data = 8'd0;
  logic       blankZeros = 1'b1;
  logic       blink = 1'b0;
  logic [2:0] brightness = 3'd7;

  logic       busyU, busyS;
  logic [2:0] indU;
  logic [3:0] indS;
  logic [7:0] segU, segS;

  int compared = 0;
  int mismatched = 0;

  // Expected words pack digits as {d3,d2,d1,d0}; d3 unused for the unsigned unit.
  logic [31:0] expU[$];
  logic [31:0] expS[$];

  int          runLen[2];
  bit          capActive[2];
  logic [3:0]  seen[2];
  logic [31:0] got[2];
  logic [31:0] cur[2];
  int          capAge[2];
  int          doneCnt[2];

  segment_display_ctrl #(
    .Size(8), .Signed("No"), .ClockPeriod_ns(20), .RefreshTime_ns(120),
    .BlinkTime_ns(1280), .BrightLevels(8)
  ) dutU (
    .Clock(clk), .ResetN(rstN), .Load(load), .Data(data), .BlankZeros(blankZeros),
    .Blink(blink), .Brightness(brightness), .Busy(busyU), .Indicators(indU), .Segments(segU)
  );

  segment_display_ctrl #(
    .Size(8), .Signed("Yes"), .ClockPeriod_ns(20), .RefreshTime_ns(160),
    .BlinkTime_ns(1280), .BrightLevels(8)
  ) dutS (
    .Clock(clk), .ResetN(rstN), .Load(load), .Data(data), .BlankZeros(blankZeros),
    .Blink(blink), .Brightness(brightness), .Busy(busyS), .Indicators(indS), .Segments(segS)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: event did not occur as required", name);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      runLen[k] = 0; capActive[k] = 0; seen[k] = '0; got[k] = '1;
      cur[k] = '1; capAge[k] = 0; doneCnt[k] = 0;
    end
  end

  // Monitor: Busy falling marks a commit; then one full scan is captured.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [3:0] ind, full, oneHot;
      logic [7:0] seg;
      logic       bsy;
      int         sel, isz;
      ind    = (k == 0) ? {1'b1, indU} : indS;
      seg    = (k == 0) ? segU : segS;
      bsy    = (k == 0) ? busyU : busyS;
      isz    = (k == 0) ? 3 : 4;
      full   = (k == 0) ? 4'h7 : 4'hF;
      oneHot = 4'b0001;
      sel = -1;
      for (int d = 0; d < 4; d++)
        if (ind == ~(oneHot << d)) sel = d;
      if (!rstN) begin
        runLen[k] = 0;
        capActive[k] = 0;
      end else begin
        if (bsy) runLen[k]++;
        else if (runLen[k] != 0) begin
          checkOutput($sformatf("busyLen[%0d]", k), runLen[k], 32'd9);
          runLen[k] = 0;
          if ((k == 0 && expU.size() == 0) || (k == 1 && expS.size() == 0))
            reportFail($sformatf("unexpectedCommit[%0d]", k));
          else begin
            cur[k] = (k == 0) ? expU.pop_front() : expS.pop_front();
            if (sel >= 0)
              checkOutput($sformatf("firstVisible[%0d].d%0d", k, sel), seg, cur[k][sel*8 +: 8]);
            else
              reportFail($sformatf("firstVisibleEnable[%0d]", k));
            capActive[k] = 1;
            seen[k] = '0;
            capAge[k] = 0;
          end
        end
        if (capActive[k]) begin
          if (sel >= 0) begin
            seen[k][sel] = 1'b1;
            got[k][sel*8 +: 8] = seg;
          end
          capAge[k]++;
          if (seen[k] == full) begin
            for (int d = 0; d < isz; d++)
              checkOutput($sformatf("digit[%0d].d%0d", k, d), got[k][d*8 +: 8], cur[k][d*8 +: 8]);
            capActive[k] = 0;
            doneCnt[k]++;
          end else if (capAge[k] > 40) begin
            reportFail($sformatf("scanCapture[%0d]", k));
            capActive[k] = 0;
            doneCnt[k]++;
          end
        end
      end
    end
  end

  task automatic waitDone(input int startU, input int startS, input int need);
    int t;
    t = 0;
    while ((doneCnt[0] < startU + need || doneCnt[1] < startS + need) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) reportFail("commitTimeout");
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit bz, input logic [31:0] eU,
                               input logic [31:0] eS);
    int startU, startS;
    startU = doneCnt[0];
    startS = doneCnt[1];
    expU.push_back(eU);
    expS.push_back(eS);
    @(negedge clk);
    blankZeros = bz;
    data = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    waitDone(startU, startS, 1);
  endtask

  initial begin
    int cnt, cntU, startU, startS, t;

    #1 rstN = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetBusyU", busyU, 0);
    checkOutput("resetBusyS", busyS, 0);
    checkOutput("resetIndU", indU, 3'b111);
    checkOutput("resetIndS", indS, 4'b1111);
    checkOutput("resetSegU", segU, 8'hFF);
    checkOutput("resetSegS", segS, 8'hFF);
    #1 rstN = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(8'd255, 1'b1, 32'hFF_A4_92_92, 32'hFF_FF_BF_F9);
    applyStimulus(8'h80,  1'b1, 32'hFF_F9_A4_80, 32'hBF_F9_A4_80);
    applyStimulus(8'hFB,  1'b1, 32'hFF_A4_92_F9, 32'hFF_FF_BF_92);
    applyStimulus(8'd0,   1'b1, 32'hFF_FF_FF_C0, 32'hFF_FF_FF_C0);
    applyStimulus(8'd0,   1'b0, 32'hFF_C0_C0_C0, 32'hFF_C0_C0_C0);
    applyStimulus(8'hFB,  1'b0, 32'hFF_A4_92_F9, 32'hBF_C0_C0_92);
    applyStimulus(8'd7,   1'b1, 32'hFF_FF_FF_F8, 32'hFF_FF_FF_F8);
    applyStimulus(8'd100, 1'b1, 32'hFF_F9_C0_C0, 32'hFF_F9_C0_C0);
    applyStimulus(8'h9C,  1'b1, 32'hFF_F9_92_82, 32'hBF_F9_C0_C0);

    // Load while busy is dropped; a load in the cycle Busy reads 0 is taken.
    startU = doneCnt[0];
    startS = doneCnt[1];
    expU.push_back(32'hFF_FF_99_A4);
    expS.push_back(32'hFF_FF_99_A4);
    @(negedge clk); data = 8'd42; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (2) @(negedge clk);
    data = 8'd99; load = 1'b1;
    @(negedge clk); load = 1'b0;
    t = 0;
    while (busyS && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) reportFail("busyFallTimeout");
    expU.push_back(32'hFF_FF_FF_90);
    expS.push_back(32'hFF_FF_FF_90);
    data = 8'd9; load = 1'b1;
    @(negedge clk); load = 1'b0;
    waitDone(startU, startS, 2);

    brightness = 3'd1;
    repeat (4) @(negedge clk);
    cnt = 0; cntU = 0;
    for (int i = 0; i < 64; i++) begin
      if (indS != 4'hF) cnt++;
      if (indU != 3'h7) cntU++;
      @(negedge clk);
    end
    checkOutput("pwmOnCyclesS", cnt, 16);
    checkOutput("pwmOnCyclesU", cntU, 16);

    brightness = 3'd7;
    blink = 1'b1;
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 128; i++) begin
      if (indS == 4'hF) cnt++;
      @(negedge clk);
    end
    checkOutput("blinkDarkCycles", cnt, 64);
    blink = 1'b0;
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 128; i++) begin
      if (indS == 4'hF) cnt++;
      @(negedge clk);
    end
    checkOutput("noBlinkDarkCycles", cnt, 0);

    // Reset in the middle of a conversion blanks everything at once.
    data = 8'd42; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("busyBeforeReset", busyS, 1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midResetBusyS", busyS, 0);
    checkOutput("midResetIndS", indS, 4'hF);
    checkOutput("midResetSegS", segS, 8'hFF);
    checkOutput("midResetIndU", indU, 3'h7);
    checkOutput("midResetSegU", segU, 8'hFF);
    @(negedge clk);
    #2 rstN = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (segS != 8'hFF || segU != 8'hFF || busyS || busyU) cnt++;
    end
    checkOutput("noStaleValueAfterReset", cnt, 0);

    checkOutput("pendingExpU", expU.size(), 0);
    checkOutput("pendingExpS", expS.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
